// File: rtl/divider_arbiter_if.sv
// Request/response bundle shared by NREQ clients of one divider.
// Latency: none, wires only.
// Backpressure: valid/ready on both the request and the response side.
interface divider_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*WIDTH-1:0]   req_x;
    logic [NREQ*WIDTH-1:0]   req_y;
    logic [NREQ-1:0]         rsp_valid;
    logic [NREQ-1:0]         rsp_ready;
    logic [WIDTH-1:0]        rsp_q;
    logic [WIDTH-1:0]        rsp_r;
    logic                    rsp_dbz;
    logic [$clog2(NREQ)-1:0] grant;
    logic                    busy;

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_q, rsp_r, rsp_dbz, grant, busy
    );

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_q, rsp_r, rsp_dbz, grant, busy
    );
endinterface

// File: rtl/divider_arbiter.sv
// Round-robin front end sharing one iterative restoring divider among NREQ requesters.
// Latency: response valid WIDTH+2 cycles after accept (2 cycles when y==0).
// Backpressure: one op in flight; result held until the granted requester takes it.
module divider_arbiter_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             valid,
    output logic             dbz,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    assign shifted = {rem, acc[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};

    // No reset: a fresh start always overrides whatever iteration is in progress.
    always_ff @(posedge clk) begin
        if (start) begin
            acc   <= x;
            rem   <= '0;
            dvs   <= y;
            cnt   <= CW'(WIDTH);
            valid <= 1'b0;
            dbz   <= (y == '0);
            busy  <= (y != '0);
        end else if (busy) begin
            if (diff[WIDTH]) begin
                rem <= shifted[WIDTH-1:0];
                acc <= {acc[WIDTH-2:0], 1'b0};
            end else begin
                rem <= diff[WIDTH-1:0];
                acc <= {acc[WIDTH-2:0], 1'b1};
            end
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                busy  <= 1'b0;
                valid <= 1'b1;
            end
        end
    end

    assign q = acc;
    assign r = rem;
endmodule

module divider_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    divider_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state;
    logic [IW-1:0]    last;
    logic [NREQ-1:0]  rsp_valid_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;
    logic             dbz_r;

    logic             sel_found;
    logic [IW-1:0]    sel_idx;
    logic [IW-1:0]    cand;
    logic             div_start;
    logic [WIDTH-1:0] div_x;
    logic [WIDTH-1:0] div_y;
    logic             div_busy;
    logic             div_valid;
    logic             div_dbz;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;

    // Walk from farthest to nearest so the requester right after 'last' wins.
    always_comb begin
        sel_found = |bus.req_valid;
        sel_idx   = last;
        cand      = last;
        for (int i = NREQ; i >= 1; i--) begin
            cand = IW'((int'(last) + i) % NREQ);
            if (bus.req_valid[cand]) sel_idx = cand;
        end
    end

    assign div_start = (state == S_IDLE) && sel_found;
    assign div_x     = bus.req_x[sel_idx*WIDTH +: WIDTH];
    assign div_y     = bus.req_y[sel_idx*WIDTH +: WIDTH];

    always_comb begin
        bus.req_ready = '0;
        if (div_start) bus.req_ready[sel_idx] = 1'b1;
    end

    divider_arbiter_div #(.WIDTH(WIDTH)) u_div (
        .clk   (clk),
        .start (div_start),
        .x     (div_x),
        .y     (div_y),
        .busy  (div_busy),
        .valid (div_valid),
        .dbz   (div_dbz),
        .q     (div_q),
        .r     (div_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            last        <= IW'(NREQ - 1);
            rsp_valid_r <= '0;
            q_r         <= '0;
            r_r         <= '0;
            dbz_r       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        last  <= sel_idx;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (div_dbz && !div_busy) begin
                        q_r         <= '0;
                        r_r         <= '0;
                        dbz_r       <= 1'b1;
                        rsp_valid_r <= {{(NREQ-1){1'b0}}, 1'b1} << last;
                        state       <= S_RESP;
                    end else if (div_valid) begin
                        q_r         <= div_q;
                        r_r         <= div_r;
                        dbz_r       <= 1'b0;
                        rsp_valid_r <= {{(NREQ-1){1'b0}}, 1'b1} << last;
                        state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready[last]) begin
                        rsp_valid_r <= '0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_q     = q_r;
    assign bus.rsp_r     = r_r;
    assign bus.rsp_dbz   = dbz_r;
    assign bus.grant     = last;
    assign bus.busy      = (state != S_IDLE);
endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
- Shares one iterative restoring divider (start/busy/valid/dbz interface; WIDTH-cycle operation) between NREQ requesters.
- Each requester has a valid/ready request channel carrying x, y and a valid/ready response channel returning q, r, dbz.
- Arbitration is round-robin, one division in flight at a time; the result is held in an output register until the granted requester accepts it.
- Sits between client engines (e.g. address or scaling units) and the shared divider instance, which is instantiated inside this block.

Parameters:
- WIDTH, 8, operand/result width; passed to the internal divider.
- NREQ, 4, number of requesters (>=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester request accept (at most one bit high)
- req_x  in  NREQ*WIDTH  dividends; requester k at [k*WIDTH +: WIDTH]
- req_y  in  NREQ*WIDTH  divisors, same packing
- rsp_valid  out  NREQ  per-requester response valid (at most one bit high)
- rsp_ready  in  NREQ  per-requester response accept
- rsp_q  out  WIDTH  quotient (shared bus, meaningful when any rsp_valid bit is high)
- rsp_r  out  WIDTH  remainder
- rsp_dbz  out  1  divide-by-zero flag for the current response
- grant  out  $clog2(NREQ)  index of the current/last granted requester
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - state=IDLE; req_ready=0; rsp_valid=0; rsp_q=0; rsp_r=0; rsp_dbz=0; busy=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority; grant=NREQ-1.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Combinationally select the first k with req_valid[k], searching from last+1 upward mod NREQ.
  - Drive req_ready[k]=1 and div.start=1 in the same cycle, with div.x/div.y muxed from requester k.
  - On the clock edge: last<=k, grant<=k, state<=WAIT.
  - No req_valid bit set: req_ready=0, start=0, stay in IDLE.
- WAIT:
  - req_ready=0; start=0.
  - If div.dbz=1 and div.busy=0: latch rsp_dbz=1, rsp_q=0, rsp_r=0; go to RESP.
  - Else if div.valid=1: latch rsp_q=div.q, rsp_r=div.r, rsp_dbz=0; go to RESP.
  - The divider's start clears valid and refreshes dbz, so stale values from a previous operation are never sampled in WAIT.
- RESP:
  - rsp_valid[grant]=1 (registered output), all other bits 0.
  - When rsp_ready[grant]=1: rsp_valid<=0, state<=IDLE.
  - rsp_ready bits of non-granted requesters are ignored.
  - rsp_q, rsp_r and rsp_dbz stay stable while rsp_valid is high.
- Latency, with the accept cycle as cycle 0:
  - Normal division: rsp_valid first high in cycle WIDTH+2.
  - y==0: rsp_valid first high in cycle 2.
  - Next accept no earlier than the cycle after the rsp handshake, i.e. at most one operation per WIDTH+3 cycles with zero response backpressure.
- Fairness: a requester holding req_valid high is granted within NREQ operations.
  - A requester that deasserts req_valid before req_ready simply loses its turn.
  - The protocol requires requesters to hold req_valid and operands stable until accepted.
- Simultaneous events:
  - A requester may raise req_valid in the same cycle its own response is being accepted; it is considered in the next IDLE cycle under normal round-robin order.
- Reset mid-operation:
  - The controller returns to IDLE and any in-flight result is dropped.
  - The divider itself has no reset; its next start overrides any ongoing iteration, so no divider output is consumed until a fresh start.
- Width rules: q and r are unsigned WIDTH bits; for y!=0, x == q*y + r with r < y.

Test Plan:
- Single requester, WIDTH=8, NREQ=4: req 0 sends x=200, y=7 -> rsp_valid[0] in cycle 10, q=28, r=4, dbz=0; grant=0.
- Divide by zero: req 2 sends x=55, y=0 -> rsp_valid[2] in cycle 2, dbz=1, q=0, r=0; the next normal request still completes correctly.
- Round-robin: all four requesters hold req_valid with distinct operands (e.g. 100/3, 255/16, 9/9, 0/5).
  - Required accept order 0,1,2,3,0.
  - Results 33r1, 15r15, 1r0, 0r0.
- Backpressure: hold rsp_ready[1]=0 for 20 cycles after rsp_valid[1] -> rsp_valid, q, r stay stable; no new req_ready while held; release gives rsp handshake, then IDLE.
- Reset mid-operation: deassert rst_n 3 cycles after accepting x=250, y=3 -> all outputs return to reset values asynchronously.
  - After release, request x=17, y=5 -> q=3, r=2, with no stale result ever presented.
- Randomized scoreboard (1000 ops, random valid/ready, random x/y including y=0) -> every response matches x/y and x%y and is delivered to the originating requester.
  - At most one bit each of req_ready/rsp_valid is high; no starvation beyond NREQ grants.
